// File: rtl/pomdp_pkg.sv
// Shared types, constants and helpers for the POMDP environment step block.
// The LFSR step function lives here so the generator and its users agree on one polynomial.
package pomdp_pkg;

  typedef logic [15:0] prob_t;
  typedef logic [15:0] reward_t;
  typedef logic [31:0] ret_t;

  localparam logic [15:0] LFSR_MASK     = 16'hB400;
  localparam logic [15:0] LFSR_ZERO_SUB = 16'hACE1;
  localparam logic [16:0] DISC_ONE      = 17'h10000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SAMP_S = 3'd1,
    ST_SAMP_O = 3'd2,
    ST_ACCUM  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/pomdp_lfsr16.sv
// 16-bit Galois LFSR used as a uniform random source; load takes priority over step.
// A zero seed would lock the register at zero, so it is substituted.
module pomdp_lfsr16
  import pomdp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] value
);

  logic [15:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = (seed == 16'h0000) ? LFSR_ZERO_SUB : seed;
    end else if (step) begin
      value_d = lfsr_next(value_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) value_q <= LFSR_ZERO_SUB;
    else     value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/pomdp_env_step.sv
// POMDP environment: per accepted action, samples s' then o by CDF walks against two LFSRs,
// then commits state, reward and discounted return.
//
// Handshake: an action transfers on a cycle where act_valid && act_ready && !load; act_ready
// is only high in IDLE while an episode is loaded and not finished. out_valid is a one-cycle
// pulse with no back-pressure.
module pomdp_env_step
  import pomdp_pkg::*;
#(
  parameter int NS = 2,
  parameter int NA = 3,
  parameter int NO = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  load,
  input  logic [$clog2(NS)-1:0]                 init_state,
  input  logic [15:0]                           seed0,
  input  logic [15:0]                           seed1,
  input  prob_t                                 discount,
  input  logic [15:0]                           max_iter,
  input  prob_t   [NA-1:0][NS-1:0][NS-1:0]      trans,
  input  prob_t   [NA-1:0][NS-1:0][NO-1:0]      observe,
  input  reward_t [NA-1:0][NS-1:0]              vec_reward,
  input  logic                                  act_valid,
  input  logic [(NA > 1 ? $clog2(NA) : 1)-1:0]  action,
  output logic                                  act_ready,
  output logic                                  out_valid,
  output logic [$clog2(NS)-1:0]                 cur_state,
  output logic [$clog2(NO)-1:0]                 observation,
  output reward_t                               reward,
  output ret_t                                  cum_reward,
  output logic [15:0]                           step_cnt,
  output logic                                  episode_done,
  output state_e                                dbg_state
);

  localparam int SW = $clog2(NS);
  localparam int OW = $clog2(NO);
  localparam int AW = (NA > 1) ? $clog2(NA) : 1;
  localparam int CW = $clog2((NS > NO) ? NS : NO);

  state_e        state_q, state_d;
  logic [CW-1:0] idx_q, idx_d, sel_q, sel_d;
  logic [16:0]   cdf_q, cdf_d, disc_pow_q, disc_pow_d;
  logic          hit_q, hit_d, active_q, active_d;
  logic [AW-1:0] act_q, act_d;
  logic [SW-1:0] ns_q, ns_d, cur_state_q, cur_state_d;
  logic [OW-1:0] obs_q, obs_d, observation_q, observation_d;
  reward_t       reward_q, reward_d;
  ret_t          cum_q, cum_d;
  logic [15:0]   step_q, step_d, max_iter_q, max_iter_d;
  prob_t         discount_q, discount_d;

  logic [15:0] lfsr0, lfsr1;
  logic        lfsr_step, done_w, ready_w;
  prob_t       entry;
  logic [16:0] r_ext, cdf_n;
  logic        hit_now;
  reward_t     reward_sel;
  logic [32:0] rew_prod, dp_prod, cum_sum;

  pomdp_lfsr16 u_lfsr0 (.clk(clk), .rst(rst), .load(load), .seed(seed0), .step(lfsr_step), .value(lfsr0));
  pomdp_lfsr16 u_lfsr1 (.clk(clk), .rst(rst), .load(load), .seed(seed1), .step(lfsr_step), .value(lfsr1));

  assign done_w     = active_q && (step_q == max_iter_q);
  assign ready_w    = (state_q == ST_IDLE) && active_q && !done_w;
  assign reward_sel = vec_reward[act_q][cur_state_q];
  assign rew_prod   = 33'(disc_pow_q) * 33'(reward_sel);
  assign dp_prod    = 33'(disc_pow_q) * 33'(discount_q);
  assign cum_sum    = {1'b0, cum_q} + 33'(rew_prod[32:16]);

  always_comb begin
    state_d = state_q;  idx_d = idx_q;  cdf_d = cdf_q;  hit_d = hit_q;  sel_d = sel_q;
    act_d = act_q;  ns_d = ns_q;  obs_d = obs_q;  active_d = active_q;
    cur_state_d = cur_state_q;  observation_d = observation_q;  reward_d = reward_q;
    cum_d = cum_q;  disc_pow_d = disc_pow_q;  step_d = step_q;
    max_iter_d = max_iter_q;  discount_d = discount_q;
    lfsr_step = 1'b0;
    entry = '0;
    r_ext = '0;
    // One walker serves both rows; only the data source and draw differ.
    if (state_q == ST_SAMP_S) begin
      entry = trans[act_q][cur_state_q][idx_q[SW-1:0]];
      r_ext = {1'b0, lfsr0};
    end else if (state_q == ST_SAMP_O) begin
      entry = observe[act_q][ns_q][idx_q[OW-1:0]];
      r_ext = {1'b0, lfsr1};
    end
    cdf_n   = cdf_q + {1'b0, entry};
    hit_now = !hit_q && (r_ext < cdf_n);

    case (state_q)
      ST_IDLE: begin
        if (act_valid && ready_w) begin
          act_d   = action;
          idx_d   = '0;
          cdf_d   = '0;
          hit_d   = 1'b0;
          sel_d   = CW'(NS - 1);
          state_d = ST_SAMP_S;
        end
      end
      ST_SAMP_S, ST_SAMP_O: begin
        cdf_d = cdf_n;
        idx_d = idx_q + CW'(1);
        if (hit_now) begin
          hit_d = 1'b1;
          sel_d = idx_q;
        end
        if (state_q == ST_SAMP_S && idx_q == CW'(NS - 1)) begin
          ns_d    = hit_now ? idx_q[SW-1:0] : sel_q[SW-1:0];
          idx_d   = '0;
          cdf_d   = '0;
          hit_d   = 1'b0;
          sel_d   = CW'(NO - 1);
          state_d = ST_SAMP_O;
        end else if (state_q == ST_SAMP_O && idx_q == CW'(NO - 1)) begin
          obs_d   = hit_now ? idx_q[OW-1:0] : sel_q[OW-1:0];
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        reward_d      = reward_sel;
        cur_state_d   = ns_q;
        observation_d = obs_q;
        cum_d         = cum_sum[32] ? 32'hFFFF_FFFF : cum_sum[31:0];
        disc_pow_d    = dp_prod[32:16];
        step_d        = step_q + 16'd1;
        lfsr_step     = 1'b1;
        state_d       = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A new episode overrides whatever step was in flight.
    if (load) begin
      state_d     = ST_IDLE;
      cur_state_d = init_state;
      reward_d    = '0;
      cum_d       = '0;
      step_d      = '0;
      disc_pow_d  = DISC_ONE;
      discount_d  = discount;
      max_iter_d  = max_iter;
      active_d    = 1'b1;
      lfsr_step   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;  idx_q <= '0;  cdf_q <= '0;  hit_q <= 1'b0;  sel_q <= '0;
      act_q <= '0;  ns_q <= '0;  obs_q <= '0;  active_q <= 1'b0;
      cur_state_q <= '0;  observation_q <= '0;  reward_q <= '0;  cum_q <= '0;
      disc_pow_q <= DISC_ONE;  step_q <= '0;  max_iter_q <= '0;  discount_q <= '0;
    end else begin
      state_q <= state_d;  idx_q <= idx_d;  cdf_q <= cdf_d;  hit_q <= hit_d;  sel_q <= sel_d;
      act_q <= act_d;  ns_q <= ns_d;  obs_q <= obs_d;  active_q <= active_d;
      cur_state_q <= cur_state_d;  observation_q <= observation_d;  reward_q <= reward_d;
      cum_q <= cum_d;  disc_pow_q <= disc_pow_d;  step_q <= step_d;
      max_iter_q <= max_iter_d;  discount_q <= discount_d;
    end
  end

  assign act_ready    = ready_w;
  assign out_valid    = (state_q == ST_DONE);
  assign cur_state    = cur_state_q;
  assign observation  = observation_q;
  assign reward       = reward_q;
  assign cum_reward   = cum_q;
  assign step_cnt     = step_q;
  assign episode_done = done_w;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_pomdp_env_step.sv
// Bench for pomdp_env_step: default 2/3/2 instance for function and corner cases,
// plus a 4-state/3-observation instance for sampling statistics.
module tb_pomdp_env_step;
  import pomdp_pkg::*;

  localparam int W = 68;

  logic clk, rst;
  logic [15:0] seed0, seed1, discount, max_iter;

  // Instance A: NS=2 NA=3 NO=2
  logic a_load, a_act_valid, a_act_ready, a_out_valid, a_episode_done;
  logic [0:0] a_init, a_cur_state, a_observation;
  logic [1:0] a_action;
  logic [15:0] a_reward, a_step_cnt;
  logic [31:0] a_cum;
  state_e a_dbg;
  logic [2:0][1:0][1:0][15:0] a_trans, a_obs;
  logic [2:0][1:0][15:0] a_vr;

  // Instance B: NS=4 NA=2 NO=3
  logic b_load, b_act_valid, b_act_ready, b_out_valid, b_episode_done;
  logic [1:0] b_init, b_cur_state, b_observation;
  logic [0:0] b_action;
  logic [15:0] b_reward, b_step_cnt;
  logic [31:0] b_cum;
  state_e b_dbg;
  logic [1:0][3:0][3:0][15:0] b_trans;
  logic [1:0][3:0][2:0][15:0] b_obs;
  logic [1:0][3:0][15:0] b_vr;

  pomdp_env_step #(.NS(2), .NA(3), .NO(2)) u_a (
    .clk(clk), .rst(rst), .load(a_load), .init_state(a_init), .seed0(seed0), .seed1(seed1),
    .discount(discount), .max_iter(max_iter), .trans(a_trans), .observe(a_obs),
    .vec_reward(a_vr), .act_valid(a_act_valid), .action(a_action), .act_ready(a_act_ready),
    .out_valid(a_out_valid), .cur_state(a_cur_state), .observation(a_observation),
    .reward(a_reward), .cum_reward(a_cum), .step_cnt(a_step_cnt),
    .episode_done(a_episode_done), .dbg_state(a_dbg));

  pomdp_env_step #(.NS(4), .NA(2), .NO(3)) u_b (
    .clk(clk), .rst(rst), .load(b_load), .init_state(b_init), .seed0(seed0), .seed1(seed1),
    .discount(discount), .max_iter(max_iter), .trans(b_trans), .observe(b_obs),
    .vec_reward(b_vr), .act_valid(b_act_valid), .action(b_action), .act_ready(b_act_ready),
    .out_valid(b_out_valid), .cur_state(b_cur_state), .observation(b_observation),
    .reward(b_reward), .cum_reward(b_cum), .step_cnt(b_step_cnt),
    .episode_done(b_episode_done), .dbg_state(b_dbg));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] lnext(input logic [15:0] v);
    logic [15:0] n;
    n = {1'b0, v[15:1]};
    if (v[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  function automatic int pick(input logic [15:0] p0, p1, p2, p3, input int n, input logic [15:0] r);
    logic [15:0] p [4];
    logic [16:0] c;
    p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
    c = '0;
    for (int k = 0; k < n; k++) begin
      c = c + {1'b0, p[k]};
      if ({1'b0, r} < c) return k;
    end
    return n - 1;
  endfunction

  logic [W-1:0] exp_q[$];
  int           acc_q[$];
  logic [3:0]   exp_b_q[$];
  int           acc_b_q[$];

  int ma_s, ma_s2, ma_o, ma_a;
  logic [15:0] ma_m0, ma_m1, ma_disc, ma_rew, ma_step;
  logic [16:0] ma_dp;
  logic [31:0] ma_cum;
  longint ma_t;
  int mb_s, mb_s2, mb_o, b_acc_n;
  logic [15:0] mb_m0, mb_m1;
  int a_ov_n = 0;
  int b_cnt [4];

  // Scoreboard push: predict every accepted action of instance A.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
    end else if (a_load) begin
      exp_q.delete();
      acc_q.delete();
      ma_s = int'(a_init);
      ma_m0 = (seed0 == 16'h0) ? 16'hACE1 : seed0;
      ma_m1 = (seed1 == 16'h0) ? 16'hACE1 : seed1;
      ma_disc = discount;
      ma_dp = 17'h10000;
      ma_cum = '0;
      ma_step = '0;
    end else if (a_act_valid && a_act_ready) begin
      ma_a = int'(a_action);
      ma_s2 = pick(a_trans[ma_a][ma_s][0], a_trans[ma_a][ma_s][1], 16'h0, 16'h0, 2, ma_m0);
      ma_o = pick(a_obs[ma_a][ma_s2][0], a_obs[ma_a][ma_s2][1], 16'h0, 16'h0, 2, ma_m1);
      ma_rew = a_vr[ma_a][ma_s];
      ma_t = ((longint'(ma_dp) * longint'(ma_rew)) >> 16) + longint'(ma_cum);
      ma_cum = (ma_t > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : ma_t[31:0];
      ma_t = (longint'(ma_dp) * longint'(ma_disc)) >> 16;
      ma_dp = ma_t[16:0];
      ma_step = ma_step + 16'd1;
      ma_m0 = lnext(ma_m0);
      ma_m1 = lnext(ma_m1);
      ma_s = ma_s2;
      exp_q.push_back({2'(ma_s), 2'(ma_o), ma_rew, ma_cum, ma_step});
      acc_q.push_back(cyc);
    end
  end

  // Scoreboard compare for instance A.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst && a_out_valid) begin
      a_ov_n++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_out_valid got 1 expected 0");
      end else begin
        e = exp_q.pop_front();
        chk("a_cur_state", 64'(a_cur_state), 64'(e[67:66]));
        chk("a_observation", 64'(a_observation), 64'(e[65:64]));
        chk("a_reward", 64'(a_reward), 64'(e[63:48]));
        chk("a_cum_reward", 64'(a_cum), 64'(e[47:16]));
        chk("a_step_cnt", 64'(a_step_cnt), 64'(e[15:0]));
        chk("a_latency", 64'(cyc - acc_q.pop_front()), 64'd6);
      end
    end
  end

  // Scoreboard push/compare for instance B.
  always @(negedge clk) begin
    logic [3:0] e;
    if (rst) begin
      exp_b_q.delete();
      acc_b_q.delete();
    end else if (b_load) begin
      exp_b_q.delete();
      acc_b_q.delete();
      mb_s = int'(b_init);
      mb_m0 = (seed0 == 16'h0) ? 16'hACE1 : seed0;
      mb_m1 = (seed1 == 16'h0) ? 16'hACE1 : seed1;
      b_acc_n = 0;
    end else if (b_act_valid && b_act_ready) begin
      mb_s2 = pick(b_trans[b_action][mb_s][0], b_trans[b_action][mb_s][1],
                   b_trans[b_action][mb_s][2], b_trans[b_action][mb_s][3], 4, mb_m0);
      mb_o = pick(b_obs[b_action][mb_s2][0], b_obs[b_action][mb_s2][1],
                  b_obs[b_action][mb_s2][2], 16'h0, 3, mb_m1);
      mb_m0 = lnext(mb_m0);
      mb_m1 = lnext(mb_m1);
      mb_s = mb_s2;
      exp_b_q.push_back({2'(mb_s), 2'(mb_o)});
      acc_b_q.push_back(cyc);
      b_acc_n++;
    end
    if (!rst && b_out_valid) begin
      if (exp_b_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_out_valid got 1 expected 0");
      end else begin
        e = exp_b_q.pop_front();
        chk("b_cur_state", 64'(b_cur_state), 64'(e[3:2]));
        chk("b_observation", 64'(b_observation), 64'(e[1:0]));
        chk("b_latency", 64'(cyc - acc_b_q.pop_front()), 64'd9);
        b_cnt[b_cur_state]++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_b_q.size() != 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", 64'(exp_q.size() + exp_b_q.size()), 64'd0);
  endtask

  task automatic a_do_load(input logic [0:0] init, input logic [15:0] s0, s1, disc, mi);
    @(posedge clk); #1;
    a_init = init; seed0 = s0; seed1 = s1; discount = disc; max_iter = mi;
    a_load = 1'b1;
    @(posedge clk); #1;
    a_load = 1'b0;
  endtask

  task automatic a_step(input int a);
    int n;
    n = 0;
    @(posedge clk); #1;
    a_act_valid = 1'b1;
    a_action = 2'(a);
    @(negedge clk);
    while (!a_act_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    a_act_valid = 1'b0;
    chk("a_accept_in_time", 64'(n < 20), 64'd1);
    wait_drain(20);
  endtask

  typedef struct {
    logic [15:0] disc;
    logic [15:0] rew;
    int          n;
    logic [31:0] exp_cum;
  } vec_t;

  initial begin
    vec_t tv [5];
    int ov0, n;

    tv[0] = '{disc: 16'hC000, rew: 16'd7209, n: 1, exp_cum: 32'd7209};
    tv[1] = '{disc: 16'hC000, rew: 16'd7209, n: 2, exp_cum: 32'd12615};
    tv[2] = '{disc: 16'h0000, rew: 16'd7209, n: 3, exp_cum: 32'd7209};
    tv[3] = '{disc: 16'hFFFF, rew: 16'd1000, n: 2, exp_cum: 32'd1999};
    tv[4] = '{disc: 16'hC000, rew: 16'd7209, n: 3, exp_cum: 32'd16670};

    rst = 1'b1;
    a_load = 0; a_act_valid = 0; a_action = '0; a_init = '0;
    b_load = 0; b_act_valid = 0; b_action = '0; b_init = '0;
    seed0 = 16'hACE1; seed1 = 16'hACE1; discount = '0; max_iter = '0;
    a_trans = '0; a_obs = '0; a_vr = '0;
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 4; k++) b_trans[0][s][k] = 16'h4000;
      b_obs[0][s][0] = 16'h5555; b_obs[0][s][1] = 16'h5555; b_obs[0][s][2] = 16'h5556;
      b_cnt[s] = 0;
    end
    b_trans[1] = '0; b_obs[1] = '0; b_vr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values, and no readiness before the first load.
    repeat (2) @(negedge clk);
    chk("rst_act_ready", 64'(a_act_ready), 64'd0);
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_cur_state", 64'(a_cur_state), 64'd0);
    chk("rst_observation", 64'(a_observation), 64'd0);
    chk("rst_reward", 64'(a_reward), 64'd0);
    chk("rst_cum_reward", 64'(a_cum), 64'd0);
    chk("rst_step_cnt", 64'(a_step_cnt), 64'd0);
    chk("rst_episode_done", 64'(a_episode_done), 64'd0);
    chk("rst_fsm_idle", 64'(a_dbg), 64'(ST_IDLE));

    // Near-deterministic transition with action 2.
    a_trans[2][0][0] = 16'hFFFF; a_trans[2][0][1] = 16'h0001;
    a_trans[2][1][0] = 16'h0001; a_trans[2][1][1] = 16'hFFFF;
    a_obs[2][0][0] = 16'h8000; a_obs[2][0][1] = 16'h8000;
    a_obs[2][1][0] = 16'h2000; a_obs[2][1][1] = 16'hE000;
    a_vr[2][0] = 16'd100; a_vr[2][1] = 16'd50;
    a_do_load(1'b0, 16'hACE1, 16'h1234, 16'hFFFF, 16'd100);
    @(negedge clk);
    chk("load_act_ready", 64'(a_act_ready), 64'd1);
    for (int i = 0; i < 8; i++) a_step(2);

    // Reward / discount table on an identity row.
    a_trans[0][0][0] = 16'hFFFF; a_trans[0][0][1] = 16'h0000;
    a_trans[0][1][0] = 16'h0000; a_trans[0][1][1] = 16'hFFFF;
    a_obs[0] = a_obs[2];
    for (int v = 0; v < 5; v++) begin
      a_vr[0][0] = tv[v].rew;
      a_vr[0][1] = 16'd0;
      a_do_load(1'b0, 16'hACE1, 16'hACE1, tv[v].disc, 16'd100);
      for (int i = 0; i < tv[v].n; i++) a_step(0);
      @(negedge clk);
      chk("tv_step_cnt", 64'(a_step_cnt), 64'(tv[v].n));
      chk("tv_cum_reward", 64'(a_cum), 64'(tv[v].exp_cum));
    end

    // Asynchronous reset during SAMP_S.
    @(posedge clk); #1;
    a_act_valid = 1'b1;
    a_action = 2'd0;
    @(posedge clk); #1;
    a_act_valid = 1'b0;
    chk("pre_rst_samp_s", 64'(a_dbg), 64'(ST_SAMP_S));
    #1 rst = 1'b1;
    #1;
    chk("arst_cur_state", 64'(a_cur_state), 64'd0);
    chk("arst_step_cnt", 64'(a_step_cnt), 64'd0);
    chk("arst_cum_reward", 64'(a_cum), 64'd0);
    chk("arst_reward", 64'(a_reward), 64'd0);
    chk("arst_act_ready", 64'(a_act_ready), 64'd0);
    chk("arst_out_valid", 64'(a_out_valid), 64'd0);
    chk("arst_fsm_idle", 64'(a_dbg), 64'(ST_IDLE));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_act_ready", 64'(a_act_ready), 64'd0);

    // Episode limit with act_valid held high.
    a_do_load(1'b0, 16'h5A5A, 16'hC3C3, 16'hC000, 16'd5);
    ov0 = a_ov_n;
    @(posedge clk); #1;
    a_act_valid = 1'b1;
    a_action = 2'd0;
    repeat (60) @(posedge clk);
    #1 a_act_valid = 1'b0;
    @(negedge clk);
    chk("limit_pulses", 64'(a_ov_n - ov0), 64'd5);
    chk("limit_done", 64'(a_episode_done), 64'd1);
    chk("limit_ready", 64'(a_act_ready), 64'd0);
    chk("limit_step_cnt", 64'(a_step_cnt), 64'd5);
    a_do_load(1'b0, 16'h5A5A, 16'hC3C3, 16'hC000, 16'd100);
    @(negedge clk);
    chk("reload_step_cnt", 64'(a_step_cnt), 64'd0);
    chk("reload_cum", 64'(a_cum), 64'd0);
    chk("reload_done", 64'(a_episode_done), 64'd0);
    a_do_load(1'b0, 16'h5A5A, 16'hC3C3, 16'hC000, 16'd0);
    @(negedge clk);
    chk("zero_iter_done", 64'(a_episode_done), 64'd1);
    chk("zero_iter_ready", 64'(a_act_ready), 64'd0);

    // Abort a step in SAMP_O with load.
    a_do_load(1'b0, 16'h0F0F, 16'hF00F, 16'hC000, 16'd100);
    ov0 = a_ov_n;
    @(posedge clk); #1;
    a_act_valid = 1'b1;
    a_action = 2'd2;
    @(posedge clk); #1;
    a_act_valid = 1'b0;
    n = 0;
    while (a_dbg != ST_SAMP_O && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("abort_reach_samp_o", 64'(a_dbg), 64'(ST_SAMP_O));
    a_init = 1'b1;
    a_load = 1'b1;
    @(posedge clk); #1;
    a_load = 1'b0;
    @(negedge clk);
    chk("abort_cur_state", 64'(a_cur_state), 64'd1);
    chk("abort_act_ready", 64'(a_act_ready), 64'd1);
    repeat (10) @(negedge clk);
    chk("abort_no_out_valid", 64'(a_ov_n - ov0), 64'd0);

    // Load and act_valid in the same cycle: load wins.
    @(posedge clk); #1;
    a_init = 1'b0;
    a_load = 1'b1;
    a_act_valid = 1'b1;
    @(posedge clk); #1;
    a_load = 1'b0;
    a_act_valid = 1'b0;
    chk("collide_fsm_idle", 64'(a_dbg), 64'(ST_IDLE));
    repeat (10) @(negedge clk);
    chk("collide_no_out_valid", 64'(a_ov_n - ov0), 64'd0);
    chk("collide_step_cnt", 64'(a_step_cnt), 64'd0);

    // Random tables and actions.
    for (int a = 0; a < 3; a++)
      for (int s = 0; s < 2; s++) begin
        a_vr[a][s] = 16'($urandom_range(0, 65535));
        for (int k = 0; k < 2; k++) begin
          a_trans[a][s][k] = 16'($urandom_range(0, 65535));
          a_obs[a][s][k] = 16'($urandom_range(0, 65535));
        end
      end
    a_do_load(1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
              16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 16'd100);
    for (int i = 0; i < 20; i++) a_step($urandom_range(0, 2));

    // Sampling statistics on the 4-state build, zero seeds.
    @(posedge clk); #1;
    seed0 = 16'h0; seed1 = 16'h0; max_iter = 16'd5000; discount = 16'hC000;
    b_init = 2'd0;
    b_load = 1'b1;
    @(posedge clk); #1;
    b_load = 1'b0;
    b_act_valid = 1'b1;
    b_action = 1'b0;
    n = 0;
    while (b_acc_n < 4096 && n < 50000) begin
      @(posedge clk); #1;
      n++;
    end
    b_act_valid = 1'b0;
    chk("b_accepts", 64'(b_acc_n), 64'd4096);
    wait_drain(40);
    for (int s = 0; s < 4; s++)
      chk($sformatf("b_count_s%0d_in_range_%0d", s, b_cnt[s]),
          64'(b_cnt[s] >= 896 && b_cnt[s] <= 1152), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog_timeout got cycle %0d expected completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
